// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device by driving open-drain
// pull-low enables on the shared clock/data pair.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 6500,
  parameter int TIMEOUT_CYC = 975000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYC - 1);
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK_CHK, WAIT_REL} state_t;
  state_t state, state_n;
  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic [19:0] cnt, cnt_n;
  logic [3:0] edge_cnt, edge_n;
  logic [15:0] frame, frame_n;
  logic ack, ack_n, done_n, err_n, clk_oe_n, data_oe_n, fall, clk_s, data_s;
  assign clk_s = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall = ~clk_sync[1] & clk_sync[2];
  assign tx_ready = state == IDLE;
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 3'b111;
      data_sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      edge_cnt <= '0;
      frame <= '0;
      ack <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy <= 1'b0;
      tx_done <= 1'b0;
      tx_err <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      state <= state_n;
      cnt <= cnt_n;
      edge_cnt <= edge_n;
      frame <= frame_n;
      ack <= ack_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy <= state_n != IDLE;
      tx_done <= done_n;
      tx_err <= err_n;
    end
  end
  // Frame bit i is what the line carries after falling edge i; bit 0 is the start bit.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    edge_n = edge_cnt;
    frame_n = frame;
    ack_n = ack;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (tx_valid) begin
        state_n = INHIBIT;
        cnt_n = '0;
        frame_n = {6'h3f, ~^tx_data, tx_data, 1'b0};
      end
      INHIBIT: begin
        state_n = cnt == INH_LAST ? REQ : INHIBIT;
        cnt_n = cnt == INH_LAST ? '0 : cnt + 20'd1;
      end
      REQ: begin
        state_n = SEND;
        cnt_n = '0;
        edge_n = '0;
      end
      SEND: begin
        cnt_n = cnt + 20'd1;
        if (fall && edge_cnt == 4'd10) begin
          state_n = ACK_CHK;
          ack_n = ~data_s;
        end else if (cnt >= TO_LAST) begin
          state_n = IDLE;
          err_n = 1'b1;
        end else if (fall) edge_n = edge_cnt + 4'd1;
      end
      ACK_CHK: begin
        cnt_n = cnt + 20'd1;
        state_n = ack ? WAIT_REL : IDLE;
        err_n = ~ack;
      end
      WAIT_REL: begin
        cnt_n = cnt + 20'd1;
        if (clk_s && data_s) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else if (cnt >= TO_LAST) begin
          state_n = IDLE;
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    clk_oe_n = state_n == INHIBIT || state_n == REQ;
    data_oe_n = state_n == REQ || (state_n == SEND && !frame_n[edge_n]);
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model clocking the host.
module tb_ps2_host_tx;
  localparam int H = 20;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_line, data_line;
  int total = 0;
  int passed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);
  ps2_host_tx #(.INHIBIT_CYC(20), .TIMEOUT_CYC(1000)) dut (
    .pclk(pclk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );
  always #5 pclk = ~pclk;
  always @(negedge pclk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic start(input logic [7:0] b, output int inh_len, output bit req_seen, output bit busy1);
    @(negedge pclk);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    busy1 = busy && !tx_ready;
    inh_len = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh_len < 100) begin
      inh_len++;
      @(negedge pclk);
    end
    req_seen = ps2_clk_oe && ps2_data_oe;
  endtask
  // Device side: reads each bit on its own rising clock edge, ACKs around falling edge 11.
  task automatic dev_run(input int stop_at, input bit ack_en, output logic [10:0] got, output bit tmo);
    int n;
    got = '0;
    tmo = 1'b0;
    n = 0;
    while (!(clk_line && !data_line)) begin
      @(negedge pclk);
      n++;
      if (n > 200) begin
        tmo = 1'b1;
        return;
      end
    end
    got[0] = data_line;
    for (int k = 1; k <= 10 && k <= stop_at; k++) begin
      repeat (H) @(negedge pclk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge pclk);
      dev_clk_low = 1'b0;
      got[k] = data_line;
    end
    if (stop_at < 11) return;
    repeat (H / 2) @(negedge pclk);
    dev_data_low = ack_en;
    repeat (H / 2) @(negedge pclk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge pclk);
    dev_clk_low = 1'b0;
    repeat (H / 2) @(negedge pclk);
    dev_data_low = 1'b0;
  endtask
  task automatic wait_result(input int d0, input int e0, output int nd, output int ne);
    for (int i = 0; i < 100 && done_cnt == d0 && err_cnt == e0; i++) @(negedge pclk);
    repeat (5) @(negedge pclk);
    nd = done_cnt - d0;
    ne = err_cnt - e0;
  endtask
  task test_reset;
    #2 rst = 1'b0;
    repeat (3) @(negedge pclk);
    total++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); else passed++;
    total++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (tx_done !== 1'b0 || tx_err !== 1'b0) $display("FAIL reset_pulses: done %b err %b want 0 0", tx_done, tx_err); else passed++;
    total++; if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", tx_ready); else passed++;
    rst = 1'b1;
  endtask
  task test_send_f4;
    int inh, nd, ne, d0, e0;
    bit req, b1, tmo;
    logic [10:0] got;
    d0 = done_cnt; e0 = err_cnt;
    start(8'hF4, inh, req, b1);
    total++; if (b1 !== 1'b1) $display("FAIL f4_busy_after_handshake: got %b want 1", b1); else passed++;
    total++; if (inh != 20) $display("FAIL f4_inhibit_len: got %0d want 20", inh); else passed++;
    total++; if (req !== 1'b1) $display("FAIL f4_req_cycle: got %b want 1", req); else passed++;
    dev_run(11, 1'b1, got, tmo);
    total++; if (tmo !== 1'b0) $display("FAIL f4_dev_start: got timeout %b want 0", tmo); else passed++;
    total++; if (got !== 11'b1_0_11110100_0) $display("FAIL f4_frame: got %b want 10111101000", got); else passed++;
    wait_result(d0, e0, nd, ne);
    total++; if (nd != 1 || ne != 0) $display("FAIL f4_result: done %0d err %0d want 1 0", nd, ne); else passed++;
    total++; if (busy !== 1'b0 || tx_ready !== 1'b1) $display("FAIL f4_idle: busy %b ready %b want 0 1", busy, tx_ready); else passed++;
  endtask
  task test_parity;
    int inh, nd, ne, d0, e0;
    bit req, b1, tmo;
    logic [10:0] got;
    d0 = done_cnt; e0 = err_cnt;
    start(8'hFF, inh, req, b1);
    dev_run(11, 1'b1, got, tmo);
    total++; if (got !== 11'b1_1_11111111_0) $display("FAIL ff_frame: got %b want 11111111110", got); else passed++;
    total++; if ((^got[9:1]) !== 1'b1) $display("FAIL ff_odd_parity: got %b want 1", ^got[9:1]); else passed++;
    wait_result(d0, e0, nd, ne);
    total++; if (nd != 1 || ne != 0) $display("FAIL ff_result: done %0d err %0d want 1 0", nd, ne); else passed++;
    d0 = done_cnt; e0 = err_cnt;
    start(8'h00, inh, req, b1);
    total++; if (inh != 20 || req !== 1'b1) $display("FAIL b2b_inhibit: len %0d req %b want 20 1", inh, req); else passed++;
    dev_run(11, 1'b1, got, tmo);
    total++; if (got !== 11'b1_1_00000000_0) $display("FAIL zero_frame: got %b want 11000000000", got); else passed++;
    total++; if ((^got[9:1]) !== 1'b1) $display("FAIL zero_odd_parity: got %b want 1", ^got[9:1]); else passed++;
    wait_result(d0, e0, nd, ne);
    total++; if (nd != 1 || ne != 0) $display("FAIL zero_result: done %0d err %0d want 1 0", nd, ne); else passed++;
  endtask
  task test_nack;
    int inh, nd, ne, d0, e0;
    bit req, b1, tmo;
    logic [10:0] got;
    d0 = done_cnt; e0 = err_cnt;
    start(8'h55, inh, req, b1);
    dev_run(11, 1'b0, got, tmo);
    total++; if (got !== 11'b1_1_01010101_0) $display("FAIL nack_frame: got %b want 11010101010", got); else passed++;
    wait_result(d0, e0, nd, ne);
    total++; if (ne != 1) $display("FAIL nack_err: got %0d pulses want 1", ne); else passed++;
    total++; if (nd != 0) $display("FAIL nack_done: got %0d pulses want 0", nd); else passed++;
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL nack_release: clk_oe %b data_oe %b want 0 0", ps2_clk_oe, ps2_data_oe); else passed++;
    total++; if (tx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL nack_idle: ready %b busy %b want 1 0", tx_ready, busy); else passed++;
  endtask
  task test_timeout;
    int inh, t;
    bit req, b1;
    start(8'hA5, inh, req, b1);
    @(negedge pclk);
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) $display("FAIL tmo_send_entry: clk_oe %b data_oe %b want 0 1", ps2_clk_oe, ps2_data_oe); else passed++;
    t = 0;
    while (!tx_err && t < 1100) begin
      @(negedge pclk);
      t++;
    end
    total++; if (t != 1000) $display("FAIL tmo_latency: got %0d cycles want 1000", t); else passed++;
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL tmo_release: clk_oe %b data_oe %b want 0 0", ps2_clk_oe, ps2_data_oe); else passed++;
    @(negedge pclk);
    total++; if (tx_err !== 1'b0 || tx_ready !== 1'b1) $display("FAIL tmo_idle: err %b ready %b want 0 1", tx_err, tx_ready); else passed++;
  endtask
  task test_reset_mid;
    int inh, nd, ne, d0, e0;
    bit req, b1, tmo;
    logic [10:0] got;
    start(8'h0F, inh, req, b1);
    dev_run(5, 1'b1, got, tmo);
    total++; if (ps2_data_oe !== 1'b1 || busy !== 1'b1) $display("FAIL mid_pre_reset: data_oe %b busy %b want 1 1", ps2_data_oe, busy); else passed++;
    #1 rst = 1'b0;
    #1;
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL mid_async_release: clk_oe %b data_oe %b want 0 0", ps2_clk_oe, ps2_data_oe); else passed++;
    total++; if (tx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_async_idle: ready %b busy %b want 1 0", tx_ready, busy); else passed++;
    repeat (3) @(negedge pclk);
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    d0 = done_cnt; e0 = err_cnt;
    start(8'hF4, inh, req, b1);
    total++; if (inh != 20 || req !== 1'b1) $display("FAIL post_reset_inhibit: len %0d req %b want 20 1", inh, req); else passed++;
    dev_run(11, 1'b1, got, tmo);
    total++; if (got !== 11'b1_0_11110100_0) $display("FAIL post_reset_frame: got %b want 10111101000", got); else passed++;
    wait_result(d0, e0, nd, ne);
    total++; if (nd != 1 || ne != 0) $display("FAIL post_reset_result: done %0d err %0d want 1 0", nd, ne); else passed++;
  endtask
  task test_ignore_valid;
    int inh, nd, ne, d0, e0;
    bit req, b1, tmo;
    logic [10:0] got;
    d0 = done_cnt; e0 = err_cnt;
    start(8'hF4, inh, req, b1);
    fork
      dev_run(11, 1'b1, got, tmo);
      begin
        repeat (100) @(negedge pclk);
        tx_data = 8'h12;
        tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
      end
    join
    total++; if (got !== 11'b1_0_11110100_0) $display("FAIL ignore_frame: got %b want 10111101000", got); else passed++;
    wait_result(d0, e0, nd, ne);
    total++; if (nd != 1 || ne != 0) $display("FAIL ignore_result: done %0d err %0d want 1 0", nd, ne); else passed++;
    repeat (10) @(negedge pclk);
    total++; if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) $display("FAIL ignore_not_queued: clk_oe %b ready %b want 0 1", ps2_clk_oe, tx_ready); else passed++;
  endtask
  initial begin
    test_reset;
    test_send_f4;
    test_parity;
    test_nack;
    test_timeout;
    test_reset_mid;
    test_ignore_valid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
